// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - lookup, update, flush and statistics signals of the branch target buffer
interface btb_predictor_if #(
    parameter int AW = 32
);
    logic          lookup_valid;
    logic [AW-1:0] lookup_pc;
    logic          pred_hit;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic [AW-1:0] upd_target;
    logic          upd_taken;
    logic          upd_jump;
    logic          upd_mispredict;
    logic          flush;
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_hits;
    logic [31:0]   stat_mispredicts;

    modport master (
        output lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_target, upd_taken, upd_jump, upd_mispredict,
        output flush,
        input  pred_hit, pred_taken, pred_target,
        input  stat_lookups, stat_hits, stat_mispredicts
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken, upd_jump, upd_mispredict,
        input  flush,
        output pred_hit, pred_taken, pred_target,
        output stat_lookups, stat_hits, stat_mispredicts
    );
endinterface

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - fully associative BTB with 2-bit counters; BTB_STATS_EN adds performance counters
module btb_predictor #(
    parameter int ENTRIES = 8,
    parameter int AW      = 32
) (
    input logic             clk,
    input logic             rst_n,
    btb_predictor_if.slave  bus
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid;
    logic [AW-1:0]      tag    [ENTRIES];
    logic [AW-1:0]      target [ENTRIES];
    logic [1:0]         ctr    [ENTRIES];
    logic [IW-1:0]      rptr;

    logic          lk_match;
    logic [AW-1:0] lk_target;
    logic [1:0]    lk_ctr;
    logic          hit;

    logic          up_hit;
    logic [IW-1:0] up_idx;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] alloc_idx;
    logic [1:0]    up_ctr_next;

    // Tags are unique, so at most one entry matches and the OR-style scan is safe.
    always_comb begin
        lk_match  = 1'b0;
        lk_target = '0;
        lk_ctr    = 2'b00;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tag[i] == bus.lookup_pc) begin
                lk_match  = 1'b1;
                lk_target = target[i];
                lk_ctr    = ctr[i];
            end
        end
    end

    assign hit             = rst_n && bus.lookup_valid && lk_match;
    assign bus.pred_hit    = hit;
    assign bus.pred_taken  = hit && lk_ctr[1];
    assign bus.pred_target = hit ? lk_target : '0;

    always_comb begin
        up_hit     = 1'b0;
        up_idx     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tag[i] == bus.upd_pc) begin
                up_hit = 1'b1;
                up_idx = IW'(i);
            end
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign alloc_idx = free_found ? free_idx : rptr;

    always_comb begin
        up_ctr_next = ctr[up_idx];
        if (bus.upd_jump) begin
            up_ctr_next = 2'b11;
        end else if (bus.upd_taken) begin
            if (ctr[up_idx] != 2'b11) up_ctr_next = ctr[up_idx] + 2'b01;
        end else begin
            if (ctr[up_idx] != 2'b00) up_ctr_next = ctr[up_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            rptr  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b00;
            end
        end else if (bus.flush) begin
            valid <= '0;
            rptr  <= '0;
        end else if (bus.upd_valid) begin
            if (up_hit) begin
                ctr[up_idx] <= up_ctr_next;
                if (bus.upd_taken) target[up_idx] <= bus.upd_target;
            end else if (bus.upd_taken) begin
                valid[alloc_idx]  <= 1'b1;
                tag[alloc_idx]    <= bus.upd_pc;
                target[alloc_idx] <= bus.upd_target;
                ctr[alloc_idx]    <= bus.upd_jump ? 2'b11 : 2'b10;
                // The pointer only moves when it actually chose the victim.
                if (!free_found) rptr <= rptr + 1'b1;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] n_lookups;
    logic [31:0] n_hits;
    logic [31:0] n_mispredicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lookups     <= '0;
            n_hits        <= '0;
            n_mispredicts <= '0;
        end else begin
            n_lookups     <= n_lookups + {31'd0, bus.lookup_valid};
            n_hits        <= n_hits + {31'd0, hit};
            n_mispredicts <= n_mispredicts + {31'd0, bus.upd_valid && bus.upd_mispredict};
        end
    end

    assign bus.stat_lookups     = n_lookups;
    assign bus.stat_hits        = n_hits;
    assign bus.stat_mispredicts = n_mispredicts;
`else
    logic unused_mispredict;
    assign unused_mispredict    = bus.upd_mispredict;
    assign bus.stat_lookups     = 32'd0;
    assign bus.stat_hits        = 32'd0;
    assign bus.stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - randomized and directed bench for btb_predictor against a table model
module tb_btb_predictor;
    localparam int ENT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    btb_predictor_if #(.AW(32)) bus ();

    btb_predictor #(.ENTRIES(ENT), .AW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          m_v   [ENT];
    logic [31:0] m_tag [ENT];
    logic [31:0] m_tgt [ENT];
    int          m_ctr [ENT];
    int          m_ptr;
    int unsigned m_lookups, m_hits, m_misp;

    function automatic int m_find(input logic [31:0] pc);
        for (int i = 0; i < ENT; i++)
            if (m_v[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        m_ptr = 0; m_lookups = 0; m_hits = 0; m_misp = 0;
    endtask

    task automatic idle();
        bus.lookup_valid = 1'b0; bus.lookup_pc = '0;
        bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0;
        bus.upd_taken = 1'b0; bus.upd_jump = 1'b0; bus.upd_mispredict = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        bus.lookup_valid = 1'b1; bus.lookup_pc = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input logic tk, input logic jp, input logic mp);
        bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_target = tg;
        bus.upd_taken = tk; bus.upd_jump = jp; bus.upd_mispredict = mp;
    endtask

    // Advance one clock and apply the table rules to whatever was driven before the edge.
    task automatic tick();
        logic lv, uv, ut, uj, um, fl;
        logic [31:0] lpc, upc, utg;
        int idx;
        lv = bus.lookup_valid; lpc = bus.lookup_pc; uv = bus.upd_valid; upc = bus.upd_pc;
        utg = bus.upd_target; ut = bus.upd_taken; uj = bus.upd_jump; um = bus.upd_mispredict;
        fl = bus.flush;
        @(posedge clk);
        if (rst_n) begin
            if (lv) m_lookups++;
            if (lv && m_find(lpc) >= 0) m_hits++;
            if (uv && um) m_misp++;
            if (fl) begin
                for (int i = 0; i < ENT; i++) m_v[i] = 1'b0;
                m_ptr = 0;
            end else if (uv) begin
                idx = m_find(upc);
                if (idx >= 0) begin
                    if (uj) m_ctr[idx] = 3;
                    else if (ut) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    else m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                    if (ut) m_tgt[idx] = utg;
                end else if (ut) begin
                    for (int i = 0; i < ENT; i++)
                        if (!m_v[i] && idx < 0) idx = i;
                    if (idx < 0) begin
                        idx = m_ptr;
                        m_ptr = (m_ptr + 1) % ENT;
                    end
                    m_v[idx] = 1'b1; m_tag[idx] = upc; m_tgt[idx] = utg;
                    m_ctr[idx] = uj ? 3 : 2;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        m_reset();
        look(32'h100);
        #1;
        checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", bus.pred_hit); end
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b want 0", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h0) begin errors++; $display("FAIL reset_target got %h want 0", bus.pred_target); end
        checks++; if ({bus.stat_lookups, bus.stat_hits, bus.stat_mispredicts} !== 96'h0) begin
            errors++; $display("FAIL reset_stats got %h %h %h want 0", bus.stat_lookups, bus.stat_hits, bus.stat_mispredicts); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
    endtask

    task automatic test_basic();
        upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
        tick(); idle();
        look(32'h100);
        @(negedge clk);
        checks++; if (bus.pred_hit !== 1'b1) begin errors++; $display("FAIL basic_hit got %b want 1", bus.pred_hit); end
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL basic_taken got %b want 1", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h200) begin errors++; $display("FAIL basic_target got %h want 200", bus.pred_target); end
        tick(); idle();
        upd(32'h100, 32'h999, 1'b0, 1'b0, 1'b0);
        tick(); tick(); idle();
        look(32'h100);
        @(negedge clk);
        checks++; if (bus.pred_hit !== 1'b1) begin errors++; $display("FAIL basic_nt_hit got %b want 1", bus.pred_hit); end
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL basic_nt_taken got %b want 0", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h200) begin errors++; $display("FAIL basic_nt_target got %h want 200", bus.pred_target); end
        tick(); idle();
    endtask

    task automatic test_replace();
        bus.flush = 1'b1;
        tick(); idle();
        for (int k = 0; k < 8; k++) begin
            upd(32'(k * 4), 32'h1000 + 32'(k), 1'b1, 1'b0, 1'b0);
            tick();
        end
        upd(32'h40, 32'h2040, 1'b1, 1'b0, 1'b0);
        tick(); idle();
        look(32'h0);
        @(negedge clk);
        checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL evict_pc0 got hit %b want 0", bus.pred_hit); end
        tick(); look(32'h4);
        @(negedge clk);
        checks++; if (bus.pred_target !== 32'h1001) begin errors++; $display("FAIL evict_pc4 got %h want 1001", bus.pred_target); end
        tick(); look(32'h40);
        @(negedge clk);
        checks++; if (bus.pred_target !== 32'h2040) begin errors++; $display("FAIL evict_new got %h want 2040", bus.pred_target); end
        tick(); idle();
        for (int k = 0; k < 16; k++) begin
            upd(32'h800 + 32'(k * 4), 32'h3000 + 32'(k), 1'b1, 1'b0, 1'b0);
            tick();
        end
        // Pointer has wrapped back to 1, so this allocation must land on entry 1 (PC 0x820).
        upd(32'h900, 32'h4900, 1'b1, 1'b0, 1'b0);
        tick(); idle();
        look(32'h820);
        @(negedge clk);
        checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL wrap_victim got hit %b want 0", bus.pred_hit); end
        tick(); look(32'h824);
        @(negedge clk);
        checks++; if (bus.pred_target !== 32'h3009) begin errors++; $display("FAIL wrap_keep got %h want 3009", bus.pred_target); end
        tick(); look(32'h900);
        @(negedge clk);
        checks++; if (bus.pred_target !== 32'h4900) begin errors++; $display("FAIL wrap_new got %h want 4900", bus.pred_target); end
        tick(); idle();
    endtask

    task automatic test_same_cycle();
        upd(32'h300, 32'h3300, 1'b1, 1'b0, 1'b0);
        look(32'h300);
        @(negedge clk);
        checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL same_cycle_hit got %b want 0", bus.pred_hit); end
        tick(); idle();
        look(32'h300);
        @(negedge clk);
        checks++; if (bus.pred_target !== 32'h3300) begin errors++; $display("FAIL same_cycle_next got %h want 3300", bus.pred_target); end
        tick(); idle();
    endtask

    task automatic test_flush();
        bus.flush = 1'b1;
        upd(32'h500, 32'h5500, 1'b1, 1'b0, 1'b0);
        tick(); idle();
        look(32'h500);
        @(negedge clk);
        checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL flush_upd got hit %b want 0", bus.pred_hit); end
        tick(); look(32'h300);
        @(negedge clk);
        checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL flush_old got hit %b want 0", bus.pred_hit); end
        tick(); idle();
    endtask

    task automatic test_jump();
        upd(32'h600, 32'h6600, 1'b1, 1'b1, 1'b0);
        tick();
        upd(32'h600, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        look(32'h600);
        @(negedge clk);
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL jump_alloc got taken %b want 1", bus.pred_taken); end
        tick();
        upd(32'h600, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        upd(32'h600, 32'h7777, 1'b0, 1'b1, 1'b0);
        tick();
        upd(32'h600, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        look(32'h600);
        @(negedge clk);
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL jump_force got taken %b want 1", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h6600) begin errors++; $display("FAIL jump_target got %h want 6600", bus.pred_target); end
        tick();
        upd(32'h680, 32'h6680, 1'b0, 1'b1, 1'b0);
        tick(); idle();
        look(32'h680);
        @(negedge clk);
        checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL nt_miss_alloc got hit %b want 0", bus.pred_hit); end
        tick(); idle();
    endtask

    task automatic test_random();
        int idx;
        logic exp_hit, exp_taken;
        logic [31:0] exp_tgt, e_l, e_h, e_m;
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.flush          = ($urandom_range(0, 31) == 0);
            bus.lookup_valid   = ($urandom_range(0, 3) != 0);
            bus.lookup_pc      = 32'($urandom_range(0, 15) * 4);
            bus.upd_valid      = ($urandom_range(0, 1) == 1);
            bus.upd_pc         = 32'($urandom_range(0, 15) * 4);
            bus.upd_target     = $urandom;
            bus.upd_taken      = ($urandom_range(0, 9) < 6);
            bus.upd_jump       = ($urandom_range(0, 7) == 0);
            bus.upd_mispredict = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            idx       = m_find(bus.lookup_pc);
            exp_hit   = bus.lookup_valid && (idx >= 0);
            exp_taken = exp_hit && (m_ctr[idx] >= 2);
            exp_tgt   = exp_hit ? m_tgt[idx] : 32'h0;
            checks++; if (bus.pred_hit !== exp_hit) begin errors++; $display("FAIL rand_hit[%0d] got %b want %b", n, bus.pred_hit, exp_hit); end
            checks++; if (bus.pred_taken !== exp_taken) begin errors++; $display("FAIL rand_taken[%0d] got %b want %b", n, bus.pred_taken, exp_taken); end
            checks++; if (bus.pred_target !== exp_tgt) begin errors++; $display("FAIL rand_target[%0d] got %h want %h", n, bus.pred_target, exp_tgt); end
            tick();
        end
        idle();
`ifdef BTB_STATS_EN
        e_l = m_lookups; e_h = m_hits; e_m = m_misp;
`else
        e_l = 32'h0; e_h = 32'h0; e_m = 32'h0;
`endif
        checks++; if (bus.stat_lookups !== e_l) begin errors++; $display("FAIL rand_stat_lookups got %0d want %0d", bus.stat_lookups, e_l); end
        checks++; if (bus.stat_hits !== e_h) begin errors++; $display("FAIL rand_stat_hits got %0d want %0d", bus.stat_hits, e_h); end
        checks++; if (bus.stat_mispredicts !== e_m) begin errors++; $display("FAIL rand_stat_misp got %0d want %0d", bus.stat_mispredicts, e_m); end
    endtask

    task automatic test_reset_mid();
        idle();
        upd(32'h700, 32'h7700, 1'b1, 1'b0, 1'b0);
        look(32'h700);
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if ({bus.stat_lookups, bus.stat_hits} !== 64'h0) begin
            errors++; $display("FAIL reset_mid_stats got %h %h want 0", bus.stat_lookups, bus.stat_hits); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        look(32'h700);
        @(negedge clk);
        checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL reset_mid_upd got hit %b want 0", bus.pred_hit); end
        tick(); idle();
    endtask

    task automatic test_stats();
        logic [31:0] e_l, e_h, e_m;
        rst_n = 1'b0;
        m_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
        tick(); idle();
        for (int i = 0; i < 10; i++) begin
            look((i < 4) ? 32'h100 : 32'h900 + 32'(i * 4));
            tick();
        end
        idle();
        upd(32'h900, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        upd(32'h904, 32'h0, 1'b0, 1'b0, 1'b1);
        tick(); idle();
        @(negedge clk);
`ifdef BTB_STATS_EN
        e_l = 32'd10; e_h = 32'd4; e_m = 32'd3;
`else
        e_l = 32'd0; e_h = 32'd0; e_m = 32'd0;
`endif
        checks++; if (bus.stat_lookups !== e_l) begin errors++; $display("FAIL stat_lookups got %0d want %0d", bus.stat_lookups, e_l); end
        checks++; if (bus.stat_hits !== e_h) begin errors++; $display("FAIL stat_hits got %0d want %0d", bus.stat_hits, e_h); end
        checks++; if (bus.stat_mispredicts !== e_m) begin errors++; $display("FAIL stat_misp got %0d want %0d", bus.stat_mispredicts, e_m); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_replace();
        test_same_cycle();
        test_flush();
        test_jump();
        test_random();
        test_reset_mid();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of fully associative entries (power of two, 2..64).
REQ-002 SHALL have parameter AW, default 32, PC and target width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port lookup_valid  input  1  fetch-stage lookup request.
REQ-006 SHALL have port lookup_pc  input  AW  fetch PC.
REQ-007 SHALL have port pred_hit  output  1  lookup_pc matches a valid entry.
REQ-008 SHALL have port pred_taken  output  1  predicted taken.
REQ-009 SHALL have port pred_target  output  AW  predicted target; 0 when pred_hit=0.
REQ-010 SHALL have port upd_valid  input  1  resolved branch/jump from decode stage.
REQ-011 SHALL have port upd_pc, upd_target  input  AW each  resolved instruction PC and target.
REQ-012 SHALL have port upd_taken, upd_jump, upd_mispredict  input  1 each  actual outcome, unconditional jump flag, prediction-was-wrong flag.
REQ-013 SHALL have port flush  input  1  invalidate all entries.
REQ-014 SHALL have ports stat_lookups, stat_hits, stat_mispredicts  output  32 each  performance counters.

Function
REQ-015 Each entry SHALL hold valid, tag (AW-bit PC), target (AW), 2-bit saturating counter.
REQ-016 Lookup SHALL be combinational: pred_hit = lookup_valid and any valid entry tag == lookup_pc; at most one entry matches.
REQ-017 pred_taken SHALL be pred_hit and counter[1]; pred_target SHALL be the matching entry target.
REQ-018 Update on hit (upd_pc matches valid entry): counter +1 saturating at 3 if upd_taken, -1 saturating at 0 otherwise; target overwritten with upd_target if upd_taken.
REQ-019 upd_jump=1 SHALL force counter to 3 on hit or allocation.
REQ-020 Update on miss with upd_taken=1 SHALL allocate: lowest-index invalid entry if any, else entry at replacement pointer; new counter = 2'b10 (2'b11 if upd_jump).
REQ-021 Update on miss with upd_taken=0 SHALL not allocate or change state.
REQ-022 Replacement pointer SHALL advance by 1 modulo ENTRIES only when it is used for eviction; wraps ENTRIES-1 -> 0.
REQ-023 Lookup and update in the same cycle SHALL see pre-update state (no bypass), including same PC.
REQ-024 flush SHALL clear all valid bits and replacement pointer at the next edge; flush and upd_valid together: flush wins, update dropped.
REQ-025 Latency: update visible to lookup exactly one cycle after the upd_valid edge.

Reset
REQ-026 rst_n low SHALL immediately clear all valid bits, counters to 2'b00, tags/targets to 0, replacement pointer to 0, stat counters to 0.
REQ-027 With rst_n low, pred_hit, pred_taken, pred_target SHALL be 0; reset mid-update SHALL discard the update.

Configuration
REQ-028 Macro BTB_STATS_EN defined: stat_lookups +1 per cycle lookup_valid=1, stat_hits +1 per cycle pred_hit=1, stat_mispredicts +1 per cycle upd_valid=1 and upd_mispredict=1; all wrap modulo 2^32; flush does not clear them.
REQ-029 Macro BTB_STATS_EN undefined: counter logic absent; stat outputs SHALL be constant 0, ports retained.

Verification
REQ-030 Reset, lookup_pc=0x100 -> pred_hit=0, pred_target=0.
REQ-031 Update pc=0x100 target=0x200 taken; next cycle lookup 0x100 -> hit=1, taken=1 (counter 2), target=0x200; two not-taken updates -> counter 0, taken=0, hit=1.
REQ-032 ENTRIES=8: allocate 8 taken PCs 0x0..0x1C, 9th 0x40 -> evicts entry 0 (PC 0x0 misses), pointer=1; 16 more misses -> pointer wraps to 1.
REQ-033 Same-cycle update and lookup of new PC 0x300 -> lookup misses that cycle, hits next cycle.
REQ-034 flush together with upd_valid taken pc=0x500 -> all lookups miss next cycle, 0x500 not allocated.
REQ-035 BTB_STATS_EN: 10 lookups (4 hits), 3 mispredict updates -> stat_lookups=10, stat_hits=4, stat_mispredicts=3; undefined -> all 0.
